// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial comparator controller.
//   state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   WIDTH_DEFAULT : default operand width in bits
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_cmp_cell.sv
// Purely combinational 1-bit magnitude compare cell.
//   a, b   : input bits
//   gt     : a > b
//   eq     : a == b
//   lt     : a < b
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first unsigned magnitude comparator.
// On an accepted start the operands are captured, then one bit per clock is
// compared from the MSB down; the first differing bit ends the comparison
// early, otherwise the operands are equal after WIDTH cycles.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request a comparison of A and B (honoured only when idle)
//   A, B   : unsigned operands, WIDTH bits
//   busy   : high while bits are being compared
//   done   : one-cycle pulse when O1/O2/O3 become valid
//   O1     : A > B
//   O2     : A == B
//   O3     : A < B
module serial_comparator_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             O1,
  output logic             O2,
  output logic             O3
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [2:0]       res_reg, res_next;   // {gt, eq, lt}

  logic bit_gt, bit_eq, bit_lt;

  // The single compare cell always looks at the currently indexed bit pair.
  bit_cmp_cell u_cell (
    .a  (a_reg[idx_reg]),
    .b  (b_reg[idx_reg]),
    .gt (bit_gt),
    .eq (bit_eq),
    .lt (bit_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      res_reg   <= 3'b000;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      idx_reg   <= idx_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    idx_next   = idx_reg;
    res_next   = res_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = A;
          b_next     = B;
          idx_next   = IDX_MSB;
          res_next   = 3'b000;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (!bit_eq) begin
          // First differing bit from the top decides the result.
          res_next   = {bit_gt, 1'b0, bit_lt};
          state_next = DONE;
        end else if (idx_reg == '0) begin
          res_next   = 3'b010;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end

      DONE: begin
        // Result registers hold until the next accepted start.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy         = (state_reg == SHIFT);
  assign done         = (state_reg == DONE);
  assign {O1, O2, O3} = res_reg;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Self-checking bench for serial_comparator_ctrl (WIDTH = 8).
// A transaction-level model predicts busy/done/result from the operand
// values seen at each accepted start; a monitor compares every cycle.
module tb_serial_comparator_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, O1, O2, O3;

  int checks = 0;
  int errors = 0;

  serial_comparator_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .O1    (O1),
    .O2    (O2),
    .O3    (O3)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_left = 0;      // edges remaining until the result appears
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;

  function automatic int latency_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    if (x == 0) return W;
    for (int p = W - 1; p >= 0; p--)
      if (x[p]) return W - p;
    return W;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = 3'b000;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else if (start) begin
      m_pend = {A > B, A == B, A < B};
      m_left = latency_of(A, B);
      m_res  = 3'b000;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    checks++;
    if ({busy, done, O1, O2, O3} !== {(m_left > 0), m_done, m_res}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t busy/done/O=%b%b_%b%b%b required %b%b_%b",
               $time, busy, done, O1, O2, O3, (m_left > 0), m_done, m_res);
    end
    if (busy && done) begin
      errors++;
      $display("FAIL busy_and_done t=%0t both high", $time);
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at a negedge one cycle
  // after done, so the DUT is idle again.
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [2:0] exp_res,
                        input int chg_cycle, input string name);
    int lat;
    int busy_n;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_n = 0;
    while (!done && lat <= 20) begin
      if (busy) busy_n++;
      if (chg_cycle != 0 && busy_n == chg_cycle) A = '1;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, busy_n, exp_lat);
    check({name, "_result"}, int'({O1, O2, O3}), int'(exp_res));
    @(negedge clk);
    check({name, "_hold"}, int'({busy, done, O1, O2, O3}), int'({2'b00, exp_res}));
    $display("txn %s A=%h B=%h latency=%0d result=%b", name, a, b, lat, {O1, O2, O3});
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({busy, done, O1, O2, O3}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // equal operands: worst-case latency
    do_cmp(8'hA5, 8'hA5, 8, 3'b010, 0, "equal_a5");
    // MSB differs: single cycle
    do_cmp(8'h80, 8'h7F, 1, 3'b100, 0, "msb_gt");
    // LSB differs; A overwritten on the 3rd busy cycle must not matter
    do_cmp(8'h12, 8'h13, 8, 3'b001, 3, "lsb_lt_chg");

    // start held high continuously
    begin
      int lat;
      A = 8'h40; B = 8'h00; start = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!done && lat <= 20) begin @(negedge clk); lat++; end
      check("held_latency", lat, 2);
      check("held_result", int'({O1, O2, O3}), 3'b100);
      @(negedge clk);
      check("held_idle_gap", int'({busy, done}), 0);
      @(negedge clk);
      check("held_reaccept", int'(busy), 1);
      check("held_reaccept_clear", int'({O1, O2, O3}), 0);
      start = 1'b0;
      lat = 0;
      while (!done && lat <= 20) begin @(negedge clk); lat++; end
      check("held_second_done", int'(done), 1);
      @(negedge clk);
      $display("txn start_held A=40 B=00 result=%b", {O1, O2, O3});
    end

    // reset during SHIFT
    begin
      A = 8'h01; B = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      #1 rst_n = 1'b0;
      #1 check("reset_abort_outputs", int'({busy, done, O1, O2, O3}), 0);
      @(negedge clk);
      check("reset_no_done", int'(done), 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_idle", int'({busy, done}), 0);
      $display("txn reset_abort A=01 B=01 aborted");
      do_cmp(8'h00, 8'hFF, 1, 3'b001, 0, "after_reset");
    end

    // randomized traffic; the per-cycle monitor does the checking
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      A = W'($urandom);
      case ($urandom_range(0, 3))
        0:       B = A;
        1:       B = A ^ W'(1 << $urandom_range(0, W - 1));
        default: B = W'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
      if (done) $display("txn random result=%b", {O1, O2, O3});
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_comparator_ctrl.md
SERIAL_COMPARATOR_CTRL -- requirements
Module: serial_comparator_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range is 2 to 32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: request to compare the operands presented on A and B.
REQ-006 Port A, input, WIDTH bits: first operand, unsigned.
REQ-007 Port B, input, WIDTH bits: second operand, unsigned.
REQ-008 Port busy, output, 1 bit: high while a comparison is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 Port O1, output, 1 bit: result A>B.
REQ-011 Port O2, output, 1 bit: result A=B.
REQ-012 Port O3, output, 1 bit: result A<B.

Function
REQ-013 The block SHALL be an FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL do all of the following at that edge: latch A and B into internal registers, load bit index idx=WIDTH-1, clear O1/O2/O3 to 000, and enter SHIFT.
REQ-015 In SHIFT, each rising edge SHALL compare latched bit A[idx] against B[idx] using one 1-bit compare cell.
REQ-016 If the bits compared in SHIFT differ, the block SHALL write O1/O3 accordingly (O2=0) and enter DONE at that edge (early termination).
REQ-017 If the bits compared in SHIFT are equal and idx=0, the block SHALL write O1O2O3=010 and enter DONE.
REQ-018 If the bits compared in SHIFT are equal and idx>0, the block SHALL decrement idx and remain in SHIFT.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency, counted from the start edge to done high: first differing bit at position p takes WIDTH-p edges; equal operands take WIDTH edges, which is the worst case.
REQ-021 busy SHALL be 1 exactly while in SHIFT; busy and done SHALL never both be 1.
REQ-022 start SHALL be ignored in SHIFT and DONE; changes on A and B after the start edge SHALL NOT affect the result.
REQ-023 Exactly one of O1/O2/O3 SHALL be 1 from done high until the next accepted start; all three SHALL be 0 at every other time.
REQ-024 The idx counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, O1=O2=O3=0, idx=0 and the operand registers to 0.
REQ-026 Reset asserted mid-comparison SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-027 Package serial_cmp_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-028 One sub-module, bit_cmp_cell, SHALL be purely combinational: inputs a and b, outputs gt, eq, lt.
REQ-029 The FSM, idx counter, operand registers and result registers SHALL live in serial_comparator_ctrl.

Verification
REQ-030 Bench, WIDTH=8: A=0xA5, B=0xA5, start pulse -> busy high for 8 cycles, done pulse on the 8th edge after start, O1O2O3=010.
REQ-031 Bench: A=0x80, B=0x7F -> done on the 1st edge after start, O1O2O3=100, busy high for exactly 1 cycle.
REQ-032 Bench: A=0x12, B=0x13 -> done on the 8th edge, O1O2O3=001; additionally, A changed to 0xFF on the 3rd busy cycle SHALL NOT alter the result.
REQ-033 Bench: start held high continuously with A=0x40, B=0x00 -> single accepted compare, done on the 2nd edge, result 100; next accept follows the DONE cycle.
REQ-034 Bench: rst_n pulsed low during SHIFT (A=0x01, B=0x01, 4th cycle) -> all outputs 0 at once, no done pulse; a subsequent start with A=0x00, B=0xFF gives done on the 1st edge and result 001.
